ps2_key_rx: RTL

- Device-to-host PS/2 keyboard receiver. Deserialises raw PS/2 clock/data frames and resolves the E0, F0 and E1 prefixes.
- Produces the 11-bit toggle-strobed ps2_key event word consumed by the console keyboard-matrix logic: bit 10 toggle, bit 9 pressed, bit 8 extended, bits 7:0 scan code.
- Sits in the clk_sys domain. Lets the core take a physical PS/2 keyboard (for example on the user port) in place of the hps_io key path.

---
 rtl/ps2_key_rx.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_rx.sv
// ============================================================================
// Module   : ps2_key_rx
// Purpose  : PS/2 keyboard receiver; deserialises frames, resolves E0/F0/E1
//            prefixes and emits a toggle-strobed 11-bit key event word.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ps2_key_rx #(
    parameter int FILT_CYC    = 8,
    parameter int TIMEOUT_CYC = 65536,
    parameter int PAUSE_SKIP  = 7
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ps2_clk_i,
    input  logic        ps2_dat_i,
    output logic [10:0] ps2_key,
    output logic        frame_err
);

    localparam int c_FILT_W = (FILT_CYC > 2) ? $clog2(FILT_CYC) : 1;
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int c_SKIP_W = (PAUSE_SKIP > 1) ? $clog2(PAUSE_SKIP + 1) : 1;

    localparam logic [c_FILT_W-1:0] c_FILT_LAST = c_FILT_W'(FILT_CYC - 1);
    localparam logic [c_TMO_W-1:0]  c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [c_SKIP_W-1:0] c_SKIP_LOAD = c_SKIP_W'(PAUSE_SKIP);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    // Reset asserts immediately but releases on a clock edge.
    logic r_rst_meta;
    logic r_rst;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_rst_meta <= 1'b1;
            r_rst      <= 1'b1;
        end else begin
            r_rst_meta <= 1'b0;
            r_rst      <= r_rst_meta;
        end
    end

    logic [1:0] w_raw;
    logic [1:0] w_filt;

    assign w_raw = {ps2_dat_i, ps2_clk_i};

    // Channel 0 is the PS/2 clock, channel 1 the data; both idle high.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic                r_s1;
            logic                r_s2;
            logic                r_lvl;
            logic [c_FILT_W-1:0] r_cnt;

            always_ff @(posedge clk_sys or posedge r_rst) begin
                if (r_rst) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_lvl <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_FILT_LAST) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    logic               r_clk_prev;
    logic               w_fall;
    logic               w_dat;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic [c_TMO_W-1:0] r_tmo_cnt;
    logic               w_timeout;
    logic               w_byte_ok;
    logic               w_bad_frame;
    logic               w_err;
    logic               r_byte_vld;
    logic [7:0]         r_byte;
    logic               r_ext;
    logic               r_rel;
    logic [c_SKIP_W-1:0] r_skip;

    assign w_fall    = r_clk_prev & ~w_filt[0];
    assign w_dat     = w_filt[1];
    // A coincident sample event takes precedence over the timeout.
    assign w_timeout = (r_state != S_IDLE) && (r_tmo_cnt == c_TMO_LAST) && !w_fall;

    always_ff @(posedge clk_sys or posedge r_rst) begin
        if (r_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_dat) w_state_nxt = S_DATA;
                S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                default:  w_state_nxt = S_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_byte_ok   = 1'b0;
        w_bad_frame = 1'b0;
        if (w_fall && (r_state == S_STOP)) begin
            w_byte_ok   = w_dat && (^{r_shift, r_parity});
            w_bad_frame = !(w_dat && (^{r_shift, r_parity}));
        end
        w_err = w_bad_frame || w_timeout || (w_fall && (r_state == S_IDLE) && w_dat);
    end

    always_ff @(posedge clk_sys or posedge r_rst) begin
        if (r_rst) begin
            r_clk_prev <= 1'b1;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tmo_cnt  <= '0;
            frame_err  <= 1'b0;
            r_byte_vld <= 1'b0;
            r_byte     <= '0;
        end else begin
            r_clk_prev <= w_filt[0];
            frame_err  <= w_err;
            r_byte_vld <= w_byte_ok;
            if (w_byte_ok) begin
                r_byte <= r_shift;
            end
            if (w_fall || (r_state == S_IDLE)) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            if (w_fall) begin
                case (r_state)
                    S_IDLE:   r_bit_cnt <= '0;
                    S_DATA: begin
                        r_shift   <= {w_dat, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    S_PARITY: r_parity <= w_dat;
                    default:  ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or posedge r_rst) begin
        if (r_rst) begin
            ps2_key <= '0;
            r_ext   <= 1'b0;
            r_rel   <= 1'b0;
            r_skip  <= '0;
        end else begin
            if (r_byte_vld) begin
                if (r_skip != '0) begin
                    r_skip <= r_skip - 1'b1;
                end else begin
                    case (r_byte)
                        8'hE1:   r_skip <= c_SKIP_LOAD;
                        8'hE0:   r_ext  <= 1'b1;
                        8'hF0:   r_rel  <= 1'b1;
                        default: begin
                            ps2_key <= {~ps2_key[10], ~r_rel, r_ext, r_byte};
                            r_ext   <= 1'b0;
                            r_rel   <= 1'b0;
                        end
                    endcase
                end
            end
            // A corrupted frame invalidates any pending prefix.
            if (w_bad_frame) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire
